dmem_burst_ctrl: RTL

Parametrised, latency-modelled data memory with a request/ready/done handshake, serving whole cache blocks.
- Reads return BLOCK_WORDS words serially after a programmable access latency, optionally critical-word-first.
- Writes accept a full block serially after a programmable write latency.
- Out-of-range addresses are flagged with an error.
- Sits behind the data cache as its backing store and miss/writeback target.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_array.sv | 44 ++++
 rtl/dmem_burst_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and width helpers for the burst data memory.
package dmem_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_BURST,
    S_WR_WAIT,
    S_WR_BURST,
    S_DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Word-offset width; a one-word block still gets a 1-bit index.
  function automatic int idx_w(input int bw);
    return (bw > 1) ? clog2(bw) : 1;
  endfunction

  function automatic int lat_w(input int rl, input int wl);
    int m;
    m = (rl > wl) ? rl : wl;
    return clog2(m + 1);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x DATA_WIDTH array: synchronous write, registered read.
// Read port returns 0 the cycle after an idle read; contents survive reset.
module dmem_array #(
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_DEPTH_LOG2  = 10,
  parameter bit INIT_DESCENDING = 1'b1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_we,
  input  logic                      i_re,
  input  logic [MEM_DEPTH_LOG2-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  output logic [DATA_WIDTH-1:0]     o_rdata
);

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

  typedef logic [DATA_WIDTH-1:0] mem_t [DEPTH];

  function automatic mem_t f_init();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = INIT_DESCENDING ? DATA_WIDTH'(DEPTH - 1 - i) : '0;
    end
    return m;
  endfunction

  mem_t r_mem = f_init();
  logic [DATA_WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_q <= '0;
    else if (i_re) r_q <= r_mem[i_addr];
    else           r_q <= '0;
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/dmem_burst_ctrl.sv
// Latency-modelled block memory: serial read/write bursts after fixed wait states.
// One request at a time; ready low while busy, requests then are ignored.
module dmem_burst_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MEM_DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS     = 4,
  parameter int RD_LATENCY      = 20,
  parameter int WR_LATENCY      = 4,
  parameter bit CRITICAL_FIRST  = 1'b0,
  parameter bit INIT_DESCENDING = 1'b1
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_rd_en,
  input  logic                              i_wr_en,
  input  logic [ADDR_WIDTH-1:0]             i_address,
  input  logic [DATA_WIDTH-1:0]             i_wr_data,
  output logic                              o_ready,
  output logic                              o_rd_valid,
  output logic [DATA_WIDTH-1:0]             o_rd_data,
  output logic [idx_w(BLOCK_WORDS)-1:0]     o_rd_word_idx,
  output logic                              o_wr_ack,
  output logic                              o_done,
  output logic                              o_err
);

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int IW    = idx_w(BLOCK_WORDS);
  localparam int BW_W  = clog2(BLOCK_WORDS) + 1;
  localparam int LW    = lat_w(RD_LATENCY, WR_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(BLOCK_WORDS - 1);
  localparam logic [BW_W-1:0]       LAST_BEAT = BW_W'(BLOCK_WORDS - 1);

  state_t                r_state;
  logic [LW-1:0]         r_lat;
  logic [BW_W-1:0]       r_beat;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_start;
  logic                  r_ready;
  logic                  r_rd_valid;
  logic [IW-1:0]         r_idx;
  logic                  r_wr_ack;
  logic                  r_done;
  logic                  r_err;

  logic [ADDR_WIDTH-1:0] w_base;
  logic [ADDR_WIDTH-1:0] w_start;
  logic                  w_oor;
  logic [BW_W-1:0]       w_nbeat;
  logic [ADDR_WIDTH-1:0] w_rd_off;
  logic [ADDR_WIDTH-1:0] w_arr_addr;
  logic                  w_re;
  logic                  w_we;
  logic [DATA_WIDTH-1:0] w_arr_q;

  assign w_base  = i_address & ~OFF_MASK;
  assign w_start = CRITICAL_FIRST ? (i_address & OFF_MASK) : '0;
  assign w_oor   = ((i_address >> MEM_DEPTH_LOG2) != '0) ||
                   (({1'b0, w_base} + (ADDR_WIDTH+1)'(BLOCK_WORDS)) > (ADDR_WIDTH+1)'(DEPTH));

  // Read address runs one beat ahead of rd_valid to cover the registered array read.
  assign w_nbeat    = (r_state == S_RD_WAIT) ? '0 : r_beat + BW_W'(1);
  assign w_rd_off   = (r_start + ADDR_WIDTH'(w_nbeat)) & OFF_MASK;
  assign w_re       = ((r_state == S_RD_WAIT) && (r_lat == '0)) ||
                      ((r_state == S_RD_BURST) && (r_beat != LAST_BEAT));
  assign w_we       = (r_state == S_WR_BURST);
  assign w_arr_addr = r_base | (w_we ? (ADDR_WIDTH'(r_beat) & OFF_MASK) : w_rd_off);

  dmem_array #(
    .DATA_WIDTH      (DATA_WIDTH),
    .MEM_DEPTH_LOG2  (MEM_DEPTH_LOG2),
    .INIT_DESCENDING (INIT_DESCENDING)
  ) u_array (
    .i_clk   (i_clk),
    .i_rst   (i_reset),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_arr_addr[MEM_DEPTH_LOG2-1:0]),
    .i_wdata (i_wr_data),
    .o_rdata (w_arr_q)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_lat      <= '0;
      r_beat     <= '0;
      r_base     <= '0;
      r_start    <= '0;
      r_ready    <= 1'b1;
      r_rd_valid <= 1'b0;
      r_idx      <= '0;
      r_wr_ack   <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_idx  <= w_re ? IW'(w_rd_off) : '0;
      case (r_state)
        S_IDLE: begin
          if (i_rd_en || i_wr_en) begin
            r_ready <= 1'b0;
            r_base  <= w_base;
            r_start <= w_start;
            r_beat  <= '0;
            if (w_oor) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else if (i_rd_en) begin
              r_state <= S_RD_WAIT;
              r_lat   <= LW'(RD_LATENCY - 1);
            end else begin
              r_state <= S_WR_WAIT;
              r_lat   <= LW'(WR_LATENCY - 1);
            end
          end
        end
        S_RD_WAIT: begin
          if (r_lat == '0) begin
            r_state    <= S_RD_BURST;
            r_rd_valid <= 1'b1;
          end else begin
            r_lat <= r_lat - LW'(1);
          end
        end
        S_RD_BURST: begin
          if (r_beat == LAST_BEAT) begin
            r_state    <= S_DONE;
            r_rd_valid <= 1'b0;
            r_done     <= 1'b1;
          end else begin
            r_beat <= r_beat + BW_W'(1);
          end
        end
        S_WR_WAIT: begin
          if (r_lat == '0) begin
            r_state  <= S_WR_BURST;
            r_wr_ack <= 1'b1;
          end else begin
            r_lat <= r_lat - LW'(1);
          end
        end
        S_WR_BURST: begin
          if (r_beat == LAST_BEAT) begin
            r_state  <= S_DONE;
            r_wr_ack <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_beat <= r_beat + BW_W'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready       = r_ready;
  assign o_rd_valid    = r_rd_valid;
  assign o_rd_data     = w_arr_q;
  assign o_rd_word_idx = r_idx;
  assign o_wr_ack      = r_wr_ack;
  assign o_done        = r_done;
  assign o_err         = r_err;

endmodule
